// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: flow-controlled single-clock wrapper around a
// combinational signed radix-2 Booth multiplier (32x32 -> 64).
// Operands are held for SETTLE_CYCLES clocks before the product is captured.
// Optional build macro: BOOTH_SEQ_ACCUM_EN (adds acc_clr / acc_value accumulator).

module boothMultiplier (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] product
);

  logic [63:0] sx;
  logic [32:0] yext;

  // Radix-2 Booth recoding: each bit pair {y[i], y[i-1]} adds, subtracts or skips x<<i
  always_comb begin
    sx      = {{32{x[31]}}, x};
    yext    = {y, 1'b0};
    product = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      case (yext[i+1 -: 2])
        2'b01:   product = product + (sx << i);
        2'b10:   product = product - (sx << i);
        default: product = product;
      endcase
    end
  end

endmodule

module booth_mult_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef BOOTH_SEQ_ACCUM_EN
  input  logic        acc_clr,
  output logic [63:0] acc_value,
`endif
  output logic [63:0] out_product,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [31:0]      reg_x, reg_y;
  logic [CNT_W-1:0] counter;
  logic [63:0]      mult_p;
  logic             ready_en;
  logic             accept;
  logic             capture;

  boothMultiplier u_mult (
    .x       (reg_x),
    .y       (reg_y),
    .product (mult_p)
  );

  assign accept  = in_valid && in_ready;
  assign capture = (state == ISSUE) && (counter == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (capture) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = in_valid ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; ready_en keeps in_ready low until the first edge after reset
  always_comb begin
    busy = (state != IDLE);
    case (state)
      IDLE:    in_ready = ready_en;
      HOLD:    in_ready = ready_en && out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Ready-enable flag set on the first clock after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // Operand latch, settle counter and product capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_x       <= '0;
      reg_y       <= '0;
      counter     <= '0;
      out_product <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (accept) begin
        reg_x   <= in_x;
        reg_y   <= in_y;
        counter <= '0;
      end else if (state == ISSUE && !capture) begin
        counter <= counter + 1'b1;
      end
      if (capture) begin
        out_product <= mult_p;
        out_valid   <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end

`ifdef BOOTH_SEQ_ACCUM_EN
  // Running sum of captured products; clear wins, then the same-edge product is added
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         acc_value <= '0;
    else if (capture) acc_value <= (acc_clr ? 64'd0 : acc_value) + mult_p;
    else if (acc_clr) acc_value <= '0;
  end
`endif

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed self-checking bench for booth_mult_sequencer (SETTLE_CYCLES=5).
module tb_booth_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        busy;
`ifdef BOOTH_SEQ_ACCUM_EN
  logic        acc_clr;
  logic [63:0] acc_value;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  booth_mult_sequencer #(.SETTLE_CYCLES(5), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef BOOTH_SEQ_ACCUM_EN
    .acc_clr     (acc_clr),
    .acc_value   (acc_value),
`endif
    .out_product (out_product),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one pair in IDLE, count edges to out_valid, check latency and product,
  // then complete the output handshake.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp);
    int  n;
    bit  rdy_seen;
    @(negedge clk);
    in_x = x; in_y = y; in_valid = 1'b1;
    @(posedge clk);             // acceptance edge E0
    #1;
    in_valid = 1'b0;
    in_x = ~x; in_y = ~y;       // must be ignored during ISSUE
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    rdy_seen = 1'b0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
      if (in_ready) rdy_seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'd5);
    check({tag, "_rdy_low"}, {63'd0, rdy_seen}, 64'd0);
    check({tag, "_product"}, out_product, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int  n;
    bit  bad;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
`ifdef BOOTH_SEQ_ACCUM_EN
    acc_clr = 1'b0;
`endif
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_product", out_product, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    do_op("p3x5", 32'd3, 32'd5, 64'd15);
    do_op("neg7x6", -32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    do_op("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    do_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    do_op("m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // Backpressure: product 110 held for 20 cycles
    @(negedge clk);
    in_x = 32'd10; in_y = 32'd11; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 50 && !out_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_latency", 64'(n), 64'd5);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_product !== 64'd110 || in_ready !== 1'b0) bad = 1'b1;
    end
    check("bp_stable", {63'd0, bad}, 64'd0);
    check("bp_product", out_product, 64'd110);
    // Release together with a new pair: HOLD bypass straight into ISSUE
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_x = 32'd2; in_y = 32'd2;
    #1;
    check("bypass_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bypass_vld_clr", {63'd0, out_valid}, 64'd0);
    check("bypass_busy", {63'd0, busy}, 64'd1);
    n = 0;
    while (n < 50 && !out_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bypass_latency", 64'(n), 64'd5);
    check("bypass_product", out_product, 64'd4);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset two cycles into ISSUE; out_product still holds 4 here
    @(negedge clk);
    in_x = 32'd9; in_y = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_product", out_product, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    out_ready = 1'b0;
    check("arst_no_stale", {63'd0, bad}, 64'd0);
    do_op("after_rst", 32'd12, -32'sd3, 64'hFFFF_FFFF_FFFF_FFDC);

`ifdef BOOTH_SEQ_ACCUM_EN
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc_clr0", acc_value, 64'd0);
    do_op("acc15", 32'd3, 32'd5, 64'd15);
    check("acc_15", acc_value, 64'd15);
    do_op("acc_m42", -32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    check("acc_m27", acc_value, 64'hFFFF_FFFF_FFFF_FFE5);
    do_op("acc100", 32'd10, 32'd10, 64'd100);
    check("acc_73", acc_value, 64'd73);
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc_clr_end", acc_value, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
